// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signals of the load/store unit.
// slave is the unit's view; master is the view of the core/memory environment.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_we;

  logic        resp_valid;
  logic        resp_err;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_dout,
    output req_ready, mem_addr, mem_din, mem_we,
    output resp_valid, resp_err, resp_we, resp_rd, resp_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_dout,
    input  req_ready, mem_addr, mem_din, mem_we,
    input  resp_valid, resp_err, resp_we, resp_rd, resp_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a word-wide memory with one write strobe;
// sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rstn,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        store_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [4:0]  rd_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_din_r;
  logic        mem_we_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic        resp_we_r;
  logic [31:0] resp_data_r;

  function automatic logic is_illegal(input logic store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = store;
      3'b101:  bad = store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          2'd3:    r[31:24] = wdata[7:0];
          default: r = word;
        endcase
      end
      3'b001: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Request FSM; every output is registered so nothing combinational reaches the memory bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      store_r      <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      rd_r         <= 5'd0;
      mem_addr_r   <= 32'h0000_0000;
      mem_din_r    <= 32'h0000_0000;
      mem_we_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_we_r    <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_we_r    <= 1'b0;
          resp_data_r  <= 32'h0000_0000;
          if (bus.req_valid) begin
            store_r  <= bus.req_store;
            funct3_r <= bus.req_funct3;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            rd_r     <= bus.req_rd;
            if (is_illegal(bus.req_store, bus.req_funct3, bus.req_addr[1:0])) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (bus.req_store && (bus.req_funct3 == 3'b010)) begin
              state_r    <= WRITE;
              mem_addr_r <= {bus.req_addr[31:2], 2'b00};
              mem_we_r   <= 1'b1;
              mem_din_r  <= bus.req_wdata;
            end else begin
              state_r    <= READ;
              mem_addr_r <= {bus.req_addr[31:2], 2'b00};
              cnt_r      <= 4'd1;
            end
          end
        end
        READ: begin
          if (cnt_r >= LAT) begin
            cnt_r <= 4'd0;
            if (store_r) begin
              state_r   <= WRITE;
              mem_we_r  <= 1'b1;
              mem_din_r <= merge(bus.mem_dout, wdata_r, funct3_r, addr_r[1:0]);
            end else begin
              state_r      <= RESP;
              mem_addr_r   <= 32'h0000_0000;
              resp_valid_r <= 1'b1;
              resp_we_r    <= (rd_r != 5'd0);
              resp_data_r  <= extract(bus.mem_dout, funct3_r, addr_r[1:0]);
            end
          end else if (cnt_r != 4'hF) begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        WRITE: begin
          state_r      <= RESP;
          mem_we_r     <= 1'b0;
          mem_din_r    <= 32'h0000_0000;
          mem_addr_r   <= 32'h0000_0000;
          resp_valid_r <= 1'b1;
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_we_r    <= 1'b0;
          resp_data_r  <= 32'h0000_0000;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_din    = mem_din_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_we    = resp_we_r;
  assign bus.resp_rd    = rd_r;
  assign bus.resp_data  = resp_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three instances (latency 2, 1, 15) sharing one
// memory model whose read data is only valid once the address has been stable long enough.
module tb_load_store_unit;

  typedef struct packed {
    logic        ready;
    logic [31:0] maddr;
    logic [31:0] mdin;
    logic        mwe;
    logic        rv;
    logic        re;
    logic        rwe;
    logic [4:0]  rrd;
    logic [31:0] rdata;
  } obs_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] mem_dout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit_if if0 ();
  load_store_unit_if if1 ();
  load_store_unit_if if2 ();

  load_store_unit #(.MEM_LATENCY(2))  dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  load_store_unit #(.MEM_LATENCY(1))  dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
  load_store_unit #(.MEM_LATENCY(15)) dut2 (.clk(clk), .rstn(rstn), .bus(if2.slave));

  assign if0.req_valid = req_valid && (sel == 2'd0);
  assign if1.req_valid = req_valid && (sel == 2'd1);
  assign if2.req_valid = req_valid && (sel == 2'd2);
  assign if0.req_store = req_store;   assign if1.req_store = req_store;   assign if2.req_store = req_store;
  assign if0.req_funct3 = req_funct3; assign if1.req_funct3 = req_funct3; assign if2.req_funct3 = req_funct3;
  assign if0.req_addr = req_addr;     assign if1.req_addr = req_addr;     assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata;   assign if1.req_wdata = req_wdata;   assign if2.req_wdata = req_wdata;
  assign if0.req_rd = req_rd;         assign if1.req_rd = req_rd;         assign if2.req_rd = req_rd;
  assign if0.mem_dout = mem_dout;     assign if1.mem_dout = mem_dout;     assign if2.mem_dout = mem_dout;

  obs_t obs_a [4];
  obs_t o;
  assign obs_a[0] = '{if0.req_ready, if0.mem_addr, if0.mem_din, if0.mem_we, if0.resp_valid,
                      if0.resp_err, if0.resp_we, if0.resp_rd, if0.resp_data};
  assign obs_a[1] = '{if1.req_ready, if1.mem_addr, if1.mem_din, if1.mem_we, if1.resp_valid,
                      if1.resp_err, if1.resp_we, if1.resp_rd, if1.resp_data};
  assign obs_a[2] = '{if2.req_ready, if2.mem_addr, if2.mem_din, if2.mem_we, if2.resp_valid,
                      if2.resp_err, if2.resp_we, if2.resp_rd, if2.resp_data};
  assign obs_a[3] = '0;
  assign o = obs_a[sel];

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 2 : (s == 2'd1) ? 1 : 15;
  endfunction

  // Memory: read data is garbage until the address has been held for the instance's latency.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_addr = 32'h0;
  int          stab = 0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'd0;
  logic [31:0] poke_data = 32'h0;

  always @(negedge clk) begin
    if (o.maddr == last_addr) begin
      if (stab < 100) stab <= stab + 1;
    end else begin
      stab <= 1;
    end
    last_addr <= o.maddr;
  end

  assign mem_dout = (stab >= lat_of(sel)) ? mem[o.maddr[9:2]] : 32'hBADD_0BAD;

  always @(posedge clk) begin
    if (o.mwe) mem[o.maddr[9:2]] <= o.mdin;
    else if (poke_en) mem[poke_idx] <= poke_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [1:0] off);
    if (st) return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) ||
                   (f3 == 3'd1 && off[0]) || (f3 == 3'd2 && off != 2'd0);
    return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ||
           ((f3 == 3'd1 || f3 == 3'd5) && off[0]) || (f3 == 3'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (8 * int'(off))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    int          sh;
    mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh = 8 * int'(off);
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
    int          lat, exp_cyc, exp_we_cyc, resp_cyc, we_cnt, we_cyc;
    logic        err, got, r_err, r_we;
    logic [4:0]  r_rd;
    logic [31:0] word, exp_data, exp_din, we_din, we_addr, r_data;
    lat = lat_of(sel);
    word = ref_mem[addr[9:2]];
    err = ref_err(st, f3, addr[1:0]);
    exp_cyc = err ? 1 : (!st ? lat + 1 : (f3 == 3'd2 ? 2 : lat + 2));
    exp_we_cyc = (f3 == 3'd2) ? 1 : lat + 1;
    exp_data = (!st && !err) ? ref_load(word, f3, addr[1:0]) : 32'h0;
    exp_din = ref_store(word, wd, f3, addr[1:0]);

    @(negedge clk);
    chk("ready_idle", {31'h0, o.ready}, 32'd1);
    chk("resp_one_cycle", {31'h0, o.rv}, 32'd0);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);

    got = 1'b0; resp_cyc = 0; we_cnt = 0; we_cyc = 0; we_din = 32'h0; we_addr = 32'h0;
    r_err = 1'b0; r_we = 1'b0; r_rd = 5'd0; r_data = 32'h0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("ready_busy", {31'h0, o.ready}, 32'd0);
        if (!err) chk("mem_addr_aligned", o.maddr, {addr[31:2], 2'b00});
      end
      if (o.mwe) begin
        we_cnt++; we_cyc = k; we_din = o.mdin; we_addr = o.maddr;
      end
      if (o.rv) begin
        got = 1'b1; resp_cyc = k;
        r_err = o.re; r_we = o.rwe; r_rd = o.rrd; r_data = o.rdata;
        chk("resp_mem_idle", o.maddr | o.mdin | {31'h0, o.mwe}, 32'h0);
      end
    end
    chk("resp_cycle", 32'(resp_cyc), 32'(exp_cyc));
    chk("resp_err", {31'h0, r_err}, {31'h0, err});
    chk("resp_we", {31'h0, r_we}, {31'h0, (!err && !st && rd != 5'd0)});
    chk("resp_rd", {27'h0, r_rd}, {27'h0, rd});
    chk("resp_data", r_data, exp_data);
    chk("we_count", 32'(we_cnt), (st && !err) ? 32'd1 : 32'd0);
    if (st && !err) begin
      chk("we_cycle", 32'(we_cyc), 32'(exp_we_cyc));
      chk("we_din", we_din, exp_din);
      chk("we_addr", we_addr, {addr[31:2], 2'b00});
      ref_mem[addr[9:2]] = exp_din;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    #1;
    chk("rst_ready", {31'h0, o.ready}, 32'd1);
    chk("rst_mem", o.maddr | o.mdin | {31'h0, o.mwe}, 32'h0);
    chk("rst_resp", {29'h0, o.rv, o.re, o.rwe}, 32'h0);
    chk("rst_rd_data", o.rdata | {27'h0, o.rrd}, 32'h0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 256; i++) poke(8'(i), (i >= 1 && i <= 16) ? $urandom : 32'h0);
    poke(8'd64, 32'h80FF_1234);
    poke(8'd128, 32'h1122_3344);

    do_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);          // lb
    do_req(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd6);          // lhu
    do_req(1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd7);          // lh misaligned
    do_req(1'b1, 3'b000, 32'h0000_0201, 32'hAAAA_AA5A, 5'd8);  // sb
    do_req(1'b1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 5'd9);  // sw
    do_req(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd0);          // lw rd=0
    do_req(1'b1, 3'b100, 32'h0000_0300, 32'h1234_5678, 5'd1);  // illegal store code
    do_req(1'b0, 3'b110, 32'h0000_0300, 32'h0, 5'd2);          // illegal load code

    for (int n = 0; n < 60; n++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             {22'h0, 8'($urandom_range(1, 16)), 2'($urandom)}, $urandom, 5'($urandom_range(0, 31)));

    @(negedge clk); sel = 2'd1;
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd3);
    do_req(1'b1, 3'b001, 32'h0000_0102, 32'h0000_CAFE, 5'd3);
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd3);
    @(negedge clk); sel = 2'd2;
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd4);
    do_req(1'b1, 3'b000, 32'h0000_0100, 32'h0000_0077, 5'd4);
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd4);

    // Reset during the read phase of an sh must cancel it without writing.
    @(negedge clk); sel = 2'd0;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0000_0202; req_wdata = 32'h0000_BEEF; req_rd = 5'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_in_read", {31'h0, o.ready}, 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_mem", o.maddr | o.mdin | {31'h0, o.mwe}, 32'h0);
    chk("async_rst_resp", {29'h0, o.rv, o.re, o.rwe}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", {31'h0, o.ready}, 32'd1);
    begin
      int bad = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (o.mwe || o.rv) bad++;
      end
      chk("no_activity_after_rst", 32'(bad), 32'd0);
    end
    do_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd10);
    do_req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd11);
    do_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
